fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of `decode`. It owns the program counter and issues in-order read requests to instruction memory. Returned words are buffered with their PCs in a small queue, and each `{PC, instruction}` pair is presented to `decode` through a valid/ready handshake. It consumes `decode`'s `next_PC_select`/`target_PC` redirect, flushes wrong-path work, and restarts fetch at the target.

## Interface
Parameters:
- `ADDRESS_BITS`, 16, width of every PC and address.
- `RESET_PC`, 0, first fetch address after reset.
- `DEPTH`, 2, instruction queue entries; must be ≥2 and a power of 2.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_addr`  out  ADDRESS_BITS  word-aligned fetch address.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_rsp_valid`  in  1  read data valid. Responses return in request order, at least 1 cycle after acceptance.
- `imem_rsp_data`  in  32  instruction word.
- `dec_valid`  out  1  `PC`/`instruction` hold a valid pair.
- `dec_ready`  in  1  decode consumes the pair this cycle.
- `PC`  out  ADDRESS_BITS  PC of the presented instruction.
- `instruction`  out  32  presented instruction word.
- `next_PC_select`  in  1  from decode; redirect request.
- `target_PC`  in  ADDRESS_BITS  from decode; redirect address.

## Operation
- State:
  - `req_pc`: next address to request.
  - `outstanding`: accepted requests not yet answered, 0..DEPTH.
  - `drop`: responses to discard, 0..DEPTH.
  - Queue of `{pc, instr}` with occupancy `occ`.
- Handshake events:
  - Request fire = `imem_req_valid & imem_req_ready`.
  - Dequeue = `dec_valid & dec_ready`.
  - Redirect = dequeue & `next_PC_select`. `next_PC_select` is ignored when no dequeue happens.
- Request issue:
  - `imem_req_valid` = `occ + outstanding - dequeue < DEPTH`, and reset is not asserted.
  - `imem_req_addr` = `req_pc`.
  - On fire, `req_pc += 4`, wrapping modulo 2^ADDRESS_BITS.
- Response handling:
  - If `drop > 0`, the word is discarded and `drop` decrements.
  - Otherwise `{pc, data}` is enqueued, where `pc` is the address of the oldest outstanding request; keep a PC shadow per outstanding request.
  - The credit rule guarantees the queue never overflows.
- Presentation:
  - `dec_valid = occ > 0`.
  - `PC`/`instruction` are the queue head.
  - When the queue is empty, `PC` = last presented PC (`RESET_PC` after reset) and `instruction` = NOP `32'h00000013`.
  - Outputs are stable while `dec_valid & !dec_ready`.
- Redirect, all in the same edge:
  - Queue flushed, including any entry enqueued that cycle.
  - `req_pc` ← `{target_PC[ADDRESS_BITS-1:2], 2'b00}`; a request fired this cycle does not increment it.
  - `drop` ← `outstanding` after this cycle's fire and response are accounted. The request fired in the redirect cycle is wrong-path and is counted.
- Simultaneous fire, response and dequeue in one cycle are all legal; the counters apply the net change.

## Timing
- Reset values (asynchronous, held while `reset`=0):
  - `imem_req_valid`=0, `dec_valid`=0.
  - `PC`=`RESET_PC`, `instruction`=NOP.
  - `req_pc`=`RESET_PC`; `outstanding`, `drop`, `occ` = 0.
- Reset asserted mid-operation clears everything immediately. Responses arriving after release that belong to pre-reset requests are the memory's responsibility; the memory is reset together with this block.
- First request: the first cycle after reset release.
- With 1-cycle memory:
  - Request cycle n, response cycle n+1, `dec_valid` cycle n+2. Load-to-decode latency is 2 cycles.
  - With `DEPTH`=2 and `dec_ready` held high, throughput is 1 instruction/cycle.
- After a redirect at cycle r:
  - First request to the target goes out at cycle r+1, subject to credit.
  - First target instruction is presented at r+3 with 1-cycle memory, plus any drop-response delay.
- `imem_req_ready`=0 holds `imem_req_addr` stable and the request pending. A redirect while a request is pending and unaccepted changes the address to the target on the next cycle.

## Structure
- Shared package `core_pkg`: `NOP` constant `32'h00000013`, `INSTR_BITS`=32, and the PC increment constant 4. `ADDRESS_BITS` stays a parameter.
- One sub-module, `fetch_fifo`: synchronous FIFO of `{ADDRESS_BITS+32}`-bit entries with depth `DEPTH`, `flush`, `push`, `pop`, and `count`. It is instantiated twice: once for the instruction queue and once for the outstanding-PC shadow.
- Credit, drop and redirect logic stay in `fetch_unit`.

## Test plan
- Reset with `RESET_PC`=0, released at cycle 0:
  - `imem_req_addr`=0 at cycle 0.
  - Stream 0,4,8,… from cycle 0.
  - `dec_valid` first high at cycle 2 with `PC`=0.
  - Before that, `instruction`=NOP.
- Backpressure with 1-cycle memory, `dec_ready`=0 for 5 cycles:
  - At most 2 requests outstanding plus queued.
  - `PC`/`instruction` are stable throughout.
  - No word is lost; PCs resume strictly in sequence.
- Redirect: PC=0x0114 presented with `next_PC_select`=1, `target_PC`=0x0128, one request outstanding:
  - That response is dropped.
  - Next presented `PC`=0x0128.
- Unaligned target: `target_PC`=0x0155 → next fetch address 0x0154.
- Wrap-around: `RESET_PC`=0xFFFC → fetch sequence 0xFFFC, 0x0000.
- `imem_req_ready` low for 3 cycles, then reset asserted mid-stream:
  - Outputs immediately return to their reset values.
  - After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/core_pkg.sv
// Shared fetch-path constants: instruction width, NOP encoding, PC stride.
// No logic; pure declarations.
// Imported by every fetch-path module.
package core_pkg;
    localparam int INSTR_BITS = 32;
    localparam logic [INSTR_BITS-1:0] NOP = 32'h0000_0013;
    localparam int PC_INC = 4;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is visible combinationally.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int WIDTH = 16 + INSTR_BITS,
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem reads, queues {PC, instr} for decode.
// Latency: request cycle n, response n+1, presented to decode n+2 with a 1-cycle memory.
// Backpressure: credit = queue occupancy + in-flight requests, capped at DEPTH; dec_ready low stalls issue.
module fetch_unit
    import core_pkg::*;
#(
    parameter int                      ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0,
    parameter int                      DEPTH        = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    imem_req_valid,
    output logic [ADDRESS_BITS-1:0] imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_rsp_valid,
    input  logic [INSTR_BITS-1:0]   imem_rsp_data,
    output logic                    dec_valid,
    input  logic                    dec_ready,
    output logic [ADDRESS_BITS-1:0] PC,
    output logic [INSTR_BITS-1:0]   instruction,
    input  logic                    next_PC_select,
    input  logic [ADDRESS_BITS-1:0] target_PC
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDRESS_BITS + INSTR_BITS;

    logic [ADDRESS_BITS-1:0] req_pc;
    logic [ADDRESS_BITS-1:0] last_pc;
    logic [ADDRESS_BITS-1:0] head_pc;
    logic [ADDRESS_BITS-1:0] rsp_pc;
    logic [INSTR_BITS-1:0]   head_instr;
    logic [EW-1:0]           q_head_dat;
    logic [CW-1:0]           occ;
    logic [CW-1:0]           outstanding;
    logic [CW-1:0]           drop;
    logic [CW-1:0]           out_next;
    logic [CW:0]             credit_use;
    logic                    fire;
    logic                    dequeue;
    logic                    redirect;
    logic                    enq;

    assign fire       = imem_req_valid & imem_req_ready;
    assign dec_valid  = (occ != '0);
    assign dequeue    = dec_valid & dec_ready;
    assign redirect   = dequeue & next_PC_select;
    assign enq        = imem_rsp_valid & (drop == '0);
    assign out_next   = outstanding + CW'(fire) - CW'(imem_rsp_valid);

    // A slot freed by this cycle's dequeue can be reused by this cycle's request.
    assign credit_use     = {1'b0, occ} + {1'b0, outstanding} - (CW+1)'(dequeue);
    assign imem_req_valid = reset & (credit_use < (CW+1)'(DEPTH));
    assign imem_req_addr  = req_pc;

    fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_q (
        .clock    (clock),
        .reset    (reset),
        .flush    (redirect),
        .push     (enq),
        .push_dat ({rsp_pc, imem_rsp_data}),
        .pop      (dequeue),
        .head_dat (q_head_dat),
        .count    (occ)
    );

    // PC of every in-flight request; never flushed so wrong-path responses still retire in order.
    fetch_fifo #(.WIDTH(ADDRESS_BITS), .DEPTH(DEPTH)) u_pc_shadow (
        .clock    (clock),
        .reset    (reset),
        .flush    (1'b0),
        .push     (fire),
        .push_dat (req_pc),
        .pop      (imem_rsp_valid),
        .head_dat (rsp_pc),
        .count    (outstanding)
    );

    assign head_pc    = q_head_dat[EW-1:INSTR_BITS];
    assign head_instr = q_head_dat[INSTR_BITS-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_pc  <= RESET_PC;
            drop    <= '0;
            last_pc <= RESET_PC;
        end else begin
            if (redirect)  req_pc <= target_PC & ~ADDRESS_BITS'(3);
            else if (fire) req_pc <= req_pc + ADDRESS_BITS'(PC_INC);

            // Everything still in flight after this edge, including this cycle's request, is wrong-path.
            if (redirect)                           drop <= out_next;
            else if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);

            if (dec_valid) last_pc <= head_pc;
        end
    end

    assign PC          = dec_valid ? head_pc    : last_pc;
    assign instruction = dec_valid ? head_instr : NOP;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle in-order memory model and a PC scoreboard.
// A second instance with RESET_PC=0xFFFC covers address wrap.
module tb_fetch_unit;
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clock          = 1'b0;
    logic        reset          = 1'b0;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        dec_ready      = 1'b1;
    logic        next_PC_select = 1'b0;
    logic [15:0] target_PC      = 16'h0;
    logic        imem_req_valid;
    logic [15:0] imem_req_addr;
    logic        dec_valid;
    logic [15:0] PC;
    logic [31:0] instruction;

    logic        w_req_valid;
    logic [15:0] w_req_addr;
    logic        w_dec_valid;
    logic [15:0] w_PC;
    logic [31:0] w_instr;

    int total = 0;
    int bad = 0;
    int deq_count = 0;
    logic [15:0] sb[$];

    fetch_unit #(.ADDRESS_BITS(16), .RESET_PC(16'h0000), .DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .PC(PC), .instruction(instruction),
        .next_PC_select(next_PC_select), .target_PC(target_PC)
    );

    fetch_unit #(.ADDRESS_BITS(16), .RESET_PC(16'hFFFC), .DEPTH(2)) dut_w (
        .clock(clock), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(1'b1),
        .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
        .dec_valid(w_dec_valid), .dec_ready(1'b0), .PC(w_PC), .instruction(w_instr),
        .next_PC_select(1'b0), .target_PC(16'h0)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {16'h5A5A, a};
    endfunction

    // 1-cycle memory: a request accepted in cycle n answers throughout cycle n+1.
    logic        m_fire;
    logic [15:0] m_addr;
    always begin
        @(negedge clock);
        m_fire = imem_req_valid && imem_req_ready;
        m_addr = imem_req_addr;
        @(posedge clock);
        #1;
        imem_rsp_valid = m_fire && reset;
        imem_rsp_data  = m_fire ? mem_word(m_addr) : 32'h0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sample at the falling edge; every dequeue is scored against the queue head.
    task automatic sample();
        logic [15:0] e;
        @(negedge clock);
        if (dec_valid && dec_ready) begin
            deq_count++;
            check("sb_avail", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("deq_pc", 32'(PC), 32'(e));
                check("deq_instr", instruction, mem_word(e));
            end
        end
    endtask

    task automatic advance();
        @(posedge clock);
        #2;
    endtask

    task automatic redirect_at(input logic [15:0] at_pc, input logic [15:0] tgt);
        logic [15:0] al;
        bit found;
        al = tgt & 16'hFFFC;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (dec_valid && PC == at_pc) begin
                found = 1'b1;
                next_PC_select = 1'b1;
                target_PC = tgt;
            end
            sample();
            advance();
            next_PC_select = 1'b0;
            target_PC = 16'h0;
        end
        check("redir_hit", 32'(found), 32'd1);
        sb.delete();
        for (int k = 0; k < 16; k++) sb.push_back(al + 16'(4 * k));
        sample();
        check("redir_req_addr", 32'(imem_req_addr), 32'(al));
        check("redir_req_vld", 32'(imem_req_valid), 32'd1);
        check("redir_r1_vld", 32'(dec_valid), 32'd0);
        check("redir_r1_pc", 32'(PC), 32'(at_pc));
        check("redir_r1_nop", instruction, NOP_W);
        advance();
        sample();
        check("redir_r2_vld", 32'(dec_valid), 32'd0);
        advance();
        sample();
        check("redir_r3_vld", 32'(dec_valid), 32'd1);
        check("redir_r3_pc", 32'(PC), 32'(al));
        advance();
    endtask

    initial begin
        logic [15:0] exp_addr;

        repeat (3) @(posedge clock);
        #2;
        check("rst_req_vld", 32'(imem_req_valid), 32'd0);
        check("rst_dec_vld", 32'(dec_valid), 32'd0);
        check("rst_pc", 32'(PC), 32'h0);
        check("rst_instr", instruction, NOP_W);
        check("rst_w_req_vld", 32'(w_req_valid), 32'd0);
        check("rst_w_pc", 32'(w_PC), 32'hFFFC);

        // Streaming from reset, decode always ready.
        for (int k = 0; k < 25; k++) sb.push_back(16'(4 * k));
        reset = 1'b1;
        deq_count = 0;
        sample();
        check("c0_req_vld", 32'(imem_req_valid), 32'd1);
        check("c0_req_addr", 32'(imem_req_addr), 32'h0);
        check("c0_dec_vld", 32'(dec_valid), 32'd0);
        check("c0_instr", instruction, NOP_W);
        check("c0_w_addr", 32'(w_req_addr), 32'hFFFC);
        check("c0_w_vld", 32'(w_req_valid), 32'd1);
        advance();
        sample();
        check("c1_req_addr", 32'(imem_req_addr), 32'h4);
        check("c1_dec_vld", 32'(dec_valid), 32'd0);
        check("c1_instr", instruction, NOP_W);
        check("c1_w_addr", 32'(w_req_addr), 32'h0000);
        check("c1_w_vld", 32'(w_req_valid), 32'd1);
        advance();
        sample();
        check("c2_dec_vld", 32'(dec_valid), 32'd1);
        check("c2_pc", 32'(PC), 32'h0);
        check("c2_w_vld", 32'(w_req_valid), 32'd0);
        check("c2_w_dec_vld", 32'(w_dec_valid), 32'd0);
        check("c2_w_instr", w_instr, NOP_W);
        advance();
        for (int i = 3; i < 12; i++) begin
            sample();
            check("stream_req_vld", 32'(imem_req_valid), 32'd1);
            advance();
        end
        check("throughput", 32'(deq_count), 32'd10);

        // Decode stalls 5 cycles; a redirect request without a dequeue must be ignored.
        dec_ready = 1'b0;
        next_PC_select = 1'b1;
        target_PC = 16'h0200;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("stall_dec_vld", 32'(dec_valid), 32'd1);
            check("stall_pc", 32'(PC), 32'(sb[0]));
            check("stall_instr", instruction, mem_word(sb[0]));
            check("stall_no_req", 32'(imem_req_valid), 32'd0);
            advance();
        end
        dec_ready = 1'b1;
        next_PC_select = 1'b0;
        target_PC = 16'h0;
        repeat (3) begin
            sample();
            advance();
        end

        redirect_at(16'h0048, 16'h010C);
        redirect_at(16'h0114, 16'h0128);
        redirect_at(16'h0130, 16'h0155);

        // Memory refuses requests for 3 cycles, then reset lands mid-stream.
        repeat (2) begin
            sample();
            advance();
        end
        exp_addr = sb[0] + 16'd8;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("hold_req_vld", 32'(imem_req_valid), 32'd1);
            check("hold_req_addr", 32'(imem_req_addr), 32'(exp_addr));
            advance();
        end
        reset = 1'b0;
        #1;
        check("mid_rst_req_vld", 32'(imem_req_valid), 32'd0);
        check("mid_rst_dec_vld", 32'(dec_valid), 32'd0);
        check("mid_rst_pc", 32'(PC), 32'h0);
        check("mid_rst_instr", instruction, NOP_W);
        sb.delete();
        for (int k = 0; k < 10; k++) sb.push_back(16'(4 * k));
        sample();
        advance();
        imem_req_ready = 1'b1;
        reset = 1'b1;
        deq_count = 0;
        sample();
        check("restart_req_vld", 32'(imem_req_valid), 32'd1);
        check("restart_req_addr", 32'(imem_req_addr), 32'h0);
        advance();
        repeat (8) begin
            sample();
            advance();
        end
        check("restart_deq_count", 32'(deq_count), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
